// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared types and constants for the dual-issue scheduler
package spu_pkg;

    localparam int NUM_REGS = 128;
    localparam int LAT_W    = 3;
    localparam int REG_W    = $clog2(NUM_REGS);

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } pipe_e;

    typedef struct packed {
        logic                       valid;
        pipe_e                      pipe;
        logic [REG_W-1:0]           rt;
        logic                       reg_write;
        logic [2:0][REG_W-1:0]      src;
        logic [2:0]                 src_en;
        logic [LAT_W-1:0]           lat;
    } issue_slot_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register countdown scoreboard with two set ports
// SCOREBOARD_FWD_EN: sources count as ready one cycle early (cnt<=1).
module reg_scoreboard
    import spu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set0_en,
    input  logic [REG_W-1:0]       set0_rt,
    input  logic [LAT_W-1:0]       set0_lat,
    input  logic                   set1_en,
    input  logic [REG_W-1:0]       set1_rt,
    input  logic [LAT_W-1:0]       set1_lat,
    input  logic [2:0][REG_W-1:0]  a_src,
    input  logic [2:0][REG_W-1:0]  b_src,
    input  logic [REG_W-1:0]       a_rt,
    input  logic [REG_W-1:0]       b_rt,
    output logic [2:0]             a_src_ready,
    output logic [2:0]             b_src_ready,
    output logic                   a_rt_free,
    output logic                   b_rt_free
);

    logic [LAT_W-1:0] cnt [NUM_REGS];

    function automatic logic src_ok(input logic [LAT_W-1:0] c);
`ifdef SCOREBOARD_FWD_EN
        return c <= LAT_W'(1);
`else
        return c == '0;
`endif
    endfunction

    // A fresh issue reloads the counter even if it was still counting down.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reset) begin
                cnt[r] <= '0;
            end else if (set0_en && set0_rt == REG_W'(r)) begin
                cnt[r] <= set0_lat;
            end else if (set1_en && set1_rt == REG_W'(r)) begin
                cnt[r] <= set1_lat;
            end else if (cnt[r] != '0) begin
                cnt[r] <= cnt[r] - LAT_W'(1);
            end
        end
    end

    always_comb begin
        a_src_ready = '0;
        b_src_ready = '0;
        for (int i = 0; i < 3; i++) begin
            a_src_ready[i] = src_ok(cnt[a_src[i]]);
            b_src_ready[i] = src_ok(cnt[b_src[i]]);
        end
        a_rt_free = (cnt[a_rt] == '0);
        b_rt_free = (cnt[b_rt] == '0);
    end

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order dual-issue pairing, pipe routing and stall counting
// SCOREBOARD_FWD_EN (in reg_scoreboard) relaxes source readiness by one cycle.
module issue_ctrl
    import spu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                a_valid,
    input  logic                b_valid,
    input  logic                a_pipe,
    input  logic                b_pipe,
    input  logic [REG_W-1:0]    a_rt,
    input  logic [REG_W-1:0]    b_rt,
    input  logic                a_reg_write,
    input  logic                b_reg_write,
    input  logic [REG_W-1:0]    a_src [0:2],
    input  logic [REG_W-1:0]    b_src [0:2],
    input  logic [2:0]          a_src_en,
    input  logic [2:0]          b_src_en,
    input  logic [LAT_W-1:0]    a_lat,
    input  logic [LAT_W-1:0]    b_lat,
    input  logic                branch_taken,
    output logic [1:0]          take,
    output logic                even_valid,
    output logic                odd_valid,
    output logic                even_slot,
    output logic                odd_slot,
    output logic [15:0]         stall_cnt
);

    issue_slot_t a, b;
    logic [2:0]  a_src_ready, b_src_ready;
    logic        a_rt_free, b_rt_free;
    logic        a_ok, b_ok, b_raw, b_waw;

    always_comb begin
        a.valid     = a_valid;
        a.pipe      = pipe_e'(a_pipe);
        a.rt        = a_rt;
        a.reg_write = a_reg_write;
        a.src_en    = a_src_en;
        a.lat       = a_lat;
        b.valid     = b_valid;
        b.pipe      = pipe_e'(b_pipe);
        b.rt        = b_rt;
        b.reg_write = b_reg_write;
        b.src_en    = b_src_en;
        b.lat       = b_lat;
        for (int i = 0; i < 3; i++) begin
            a.src[i] = a_src[i];
            b.src[i] = b_src[i];
        end
    end

    reg_scoreboard u_sb (
        .clk         (clk),
        .reset       (reset),
        .set0_en     (a_ok && a.reg_write),
        .set0_rt     (a.rt),
        .set0_lat    (a.lat),
        .set1_en     (b_ok && b.reg_write),
        .set1_rt     (b.rt),
        .set1_lat    (b.lat),
        .a_src       (a.src),
        .b_src       (b.src),
        .a_rt        (a.rt),
        .b_rt        (b.rt),
        .a_src_ready (a_src_ready),
        .b_src_ready (b_src_ready),
        .a_rt_free   (a_rt_free),
        .b_rt_free   (b_rt_free)
    );

    always_comb begin
        a_ok = a.valid && !branch_taken && !reset
            && (&(a_src_ready | ~a.src_en))
            && (!a.reg_write || a_rt_free);

        // B must not depend on or overwrite A's result within the same pair.
        b_raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (a.reg_write && b.src_en[i] && b.src[i] == a.rt) begin
                b_raw = 1'b1;
            end
        end
        b_waw = a.reg_write && b.reg_write && (b.rt == a.rt);

        b_ok = a_ok && b.valid && (b.pipe != a.pipe)
            && (&(b_src_ready | ~b.src_en))
            && (!b.reg_write || b_rt_free)
            && !b_raw && !b_waw;

        take = b_ok ? 2'd2 : (a_ok ? 2'd1 : 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            even_valid <= 1'b0;
            odd_valid  <= 1'b0;
            even_slot  <= 1'b0;
            odd_slot   <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            even_valid <= (a_ok && a.pipe == EVEN) || (b_ok && b.pipe == EVEN);
            odd_valid  <= (a_ok && a.pipe == ODD)  || (b_ok && b.pipe == ODD);
            even_slot  <= b_ok && b.pipe == EVEN;
            odd_slot   <= b_ok && b.pipe == ODD;
            if (a.valid && take == 2'd0 && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - scenario tests for issue_ctrl with an output scoreboard queue
module tb_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, a_pipe, b_pipe;
    logic [6:0]  a_rt, b_rt;
    logic        a_reg_write, b_reg_write;
    logic [6:0]  a_src [0:2];
    logic [6:0]  b_src [0:2];
    logic [2:0]  a_src_en, b_src_en;
    logic [2:0]  a_lat, b_lat;
    logic        branch_taken;
    logic [1:0]  take;
    logic        even_valid, odd_valid, even_slot, odd_slot;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;
    logic [3:0] sb_q [$];

    issue_ctrl dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .b_valid(b_valid),
        .a_pipe(a_pipe), .b_pipe(b_pipe),
        .a_rt(a_rt), .b_rt(b_rt),
        .a_reg_write(a_reg_write), .b_reg_write(b_reg_write),
        .a_src(a_src), .b_src(b_src),
        .a_src_en(a_src_en), .b_src_en(b_src_en),
        .a_lat(a_lat), .b_lat(b_lat),
        .branch_taken(branch_taken), .take(take),
        .even_valid(even_valid), .odd_valid(odd_valid),
        .even_slot(even_slot), .odd_slot(odd_slot),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Expected {even_valid, even_slot, odd_valid, odd_slot} after each clock edge.
    always @(posedge clk) begin
        logic [3:0] exp_o;
        #1;
        if (sb_q.size() != 0) begin
            exp_o = sb_q.pop_front();
            checks++;
            if ({even_valid, even_slot, odd_valid, odd_slot} !== exp_o) begin
                errors++;
                $display("FAIL strobes t=%0t got=%b exp=%b", $time,
                         {even_valid, even_slot, odd_valid, odd_slot}, exp_o);
            end
        end
    end

    task automatic adv(input logic [3:0] exp_o);
        sb_q.push_back(exp_o);
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        a_valid = 0; b_valid = 0; a_pipe = 0; b_pipe = 1;
        a_rt = 0; b_rt = 0; a_reg_write = 0; b_reg_write = 0;
        a_src_en = 0; b_src_en = 0; a_lat = 1; b_lat = 1;
        branch_taken = 0;
        for (int i = 0; i < 3; i++) begin
            a_src[i] = 0;
            b_src[i] = 0;
        end
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) adv(4'b0000);
    endtask

    task automatic set_pair_indep();
        clear_inputs();
        a_valid = 1; a_pipe = 0; a_rt = 3; a_reg_write = 1; a_lat = 1;
        a_src[0] = 1; a_src[1] = 2; a_src_en = 3'b011;
        b_valid = 1; b_pipe = 1; b_rt = 4; b_reg_write = 1; b_lat = 1;
        b_src[0] = 5; b_src_en = 3'b001;
    endtask

    task automatic test_reset();
        set_pair_indep();
        reset = 1;
        @(negedge clk);
        checks++;
        if (take !== 2'd0) begin errors++; $display("FAIL reset_take got=%0d exp=0", take); end
        adv(4'b0000);
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
        reset = 0;
        idle(1);
    endtask

    task automatic test_dual_issue();
        set_pair_indep();
        @(negedge clk);
        checks++;
        if (take !== 2'd2) begin errors++; $display("FAIL dual_take got=%0d exp=2", take); end
        adv(4'b1011);
        idle(2);
    endtask

    task automatic test_same_pipe();
        clear_inputs();
        a_valid = 1; a_pipe = 1; a_rt = 10; a_reg_write = 1;
        b_valid = 1; b_pipe = 1; b_rt = 11; b_reg_write = 1;
        @(negedge clk);
        checks++;
        if (take !== 2'd1) begin errors++; $display("FAIL same_pipe_take got=%0d exp=1", take); end
        adv(4'b0010);
        clear_inputs();
        a_valid = 1; a_pipe = 1; a_rt = 11; a_reg_write = 1;
        @(negedge clk);
        checks++;
        if (take !== 2'd1) begin errors++; $display("FAIL shifted_take got=%0d exp=1", take); end
        adv(4'b0010);
        idle(2);
    endtask

    task automatic test_sb_raw();
        int n_stall;
        logic [15:0] s0;
`ifdef SCOREBOARD_FWD_EN
        n_stall = 3;
`else
        n_stall = 4;
`endif
        clear_inputs();
        a_valid = 1; a_pipe = 0; a_rt = 7; a_reg_write = 1; a_lat = 4;
        @(negedge clk);
        checks++;
        if (take !== 2'd1) begin errors++; $display("FAIL raw_producer_take got=%0d exp=1", take); end
        adv(4'b1000);
        s0 = stall_cnt;
        clear_inputs();
        a_valid = 1; a_pipe = 0; a_src[0] = 7; a_src_en = 3'b001;
        for (int i = 0; i < n_stall; i++) begin
            @(negedge clk);
            checks++;
            if (take !== 2'd0) begin errors++; $display("FAIL raw_stall_%0d got=%0d exp=0", i, take); end
            adv(4'b0000);
        end
        @(negedge clk);
        checks++;
        if (take !== 2'd1) begin errors++; $display("FAIL raw_release got=%0d exp=1", take); end
        adv(4'b1000);
        checks++;
        if (stall_cnt !== s0 + 16'(n_stall)) begin
            errors++; $display("FAIL raw_stall_cnt got=%0d exp=%0d", stall_cnt, s0 + 16'(n_stall));
        end
        idle(1);
    endtask

    task automatic test_intra_pair();
        clear_inputs();
        a_valid = 1; a_pipe = 0; a_rt = 9; a_reg_write = 1;
        b_valid = 1; b_pipe = 1; b_src[0] = 9; b_src_en = 3'b001;
        @(negedge clk);
        checks++;
        if (take !== 2'd1) begin errors++; $display("FAIL intra_raw_take got=%0d exp=1", take); end
        adv(4'b1000);
        idle(2);
        clear_inputs();
        a_valid = 1; a_pipe = 0; a_rt = 12; a_reg_write = 1;
        b_valid = 1; b_pipe = 1; b_rt = 12; b_reg_write = 1;
        @(negedge clk);
        checks++;
        if (take !== 2'd1) begin errors++; $display("FAIL intra_waw_take got=%0d exp=1", take); end
        adv(4'b1000);
        idle(2);
    endtask

    task automatic test_flush();
        logic [15:0] s0;
        set_pair_indep();
        a_rt = 20; a_src[0] = 21; a_src[1] = 21; b_rt = 22;
        branch_taken = 1;
        s0 = stall_cnt;
        @(negedge clk);
        checks++;
        if (take !== 2'd0) begin errors++; $display("FAIL flush_take got=%0d exp=0", take); end
        adv(4'b0000);
        checks++;
        if (stall_cnt !== s0 + 16'd1) begin
            errors++; $display("FAIL flush_stall_cnt got=%0d exp=%0d", stall_cnt, s0 + 16'd1);
        end
        branch_taken = 0;
        @(negedge clk);
        checks++;
        if (take !== 2'd2) begin errors++; $display("FAIL post_flush_take got=%0d exp=2", take); end
        adv(4'b1011);
        idle(2);
    endtask

    task automatic test_reset_midflight();
        clear_inputs();
        a_valid = 1; a_pipe = 0; a_rt = 7; a_reg_write = 1; a_lat = 7;
        @(negedge clk);
        checks++;
        if (take !== 2'd1) begin errors++; $display("FAIL mid_producer_take got=%0d exp=1", take); end
        adv(4'b1000);
        clear_inputs();
        a_valid = 1; a_pipe = 0; a_src[0] = 7; a_src_en = 3'b001;
        reset = 1;
        @(negedge clk);
        checks++;
        if (take !== 2'd0) begin errors++; $display("FAIL mid_reset_take got=%0d exp=0", take); end
        adv(4'b0000);
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_stall got=%0d exp=0", stall_cnt); end
        reset = 0;
        @(negedge clk);
        checks++;
        if (take !== 2'd1) begin errors++; $display("FAIL after_reset_take got=%0d exp=1", take); end
        adv(4'b1000);
        idle(2);
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_dual_issue();
        test_same_pipe();
        test_sb_raw();
        test_intra_pair();
        test_flush();
        test_reset_midflight();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d exp=0", sb_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
